dac_code_sequencer: RTL and testbench

//   Digital stage directly upstream of the 4-bit R-2R DAC macro; produces the D3..D0 code on ui_in[3:0].

---
 rtl/dac_code_sequencer.sv | 177 +++++++++++++++++
 tb/tb_dac_code_sequencer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_code_sequencer.sv
// dac_code_sequencer
//   Drives the D3..D0 code of the R-2R DAC macro. Plays user-written samples
//   from a small FIFO or generates sawtooth/triangle ramps, one new registered
//   code per sample tick. The sample rate is clk / (rate_div + 1).
//
// Ports
//   clk           system clock
//   rst           asynchronous, active-high reset
//   run           1 = sequencer advancing, 0 = frozen (divider held at 0)
//   mode          00 FIFO play, 01 sawtooth, 10 triangle, 11 hold
//   rate_div      sample period minus 1, in clk cycles
//   wr_valid      sample write request
//   wr_data       sample to push
//   wr_ready      FIFO not full; a push happens on wr_valid && wr_ready
//   clr_underrun  clears the sticky underrun flag (and the event counter)
//   dac_code      code to the DAC (registered)
//   sample_stb    one-cycle pulse in the cycle a new dac_code appears
//   fifo_level    entries currently held (0..DEPTH)
//   underrun      sticky: a FIFO-mode tick found the FIFO empty
//   underrun_cnt  saturating count of underrun events (only when
//                 DAC_SEQ_UNDERRUN_CNT_EN is defined)
//
// Build option
//   DAC_SEQ_UNDERRUN_CNT_EN  adds the underrun_cnt output and its counter.
//
// Triangle direction state
//   state     | meaning
//   DIR_UP    | next triangle tick increments (forced here outside triangle mode)
//   DIR_DOWN  | next triangle tick decrements

module dac_code_sequencer #(
   parameter int CODE_W = 4,
   parameter int DEPTH  = 8,
   parameter int DIV_W  = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     run,
   input  logic [1:0]               mode,
   input  logic [DIV_W-1:0]         rate_div,
   input  logic                     wr_valid,
   input  logic [CODE_W-1:0]        wr_data,
   output logic                     wr_ready,
   input  logic                     clr_underrun,
   output logic [CODE_W-1:0]        dac_code,
   output logic                     sample_stb,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic                     underrun
`ifdef DAC_SEQ_UNDERRUN_CNT_EN
   ,
   output logic [7:0]               underrun_cnt
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [CODE_W-1:0] CODE_MAX = '1;

   typedef enum logic [1:0] {
      MODE_FIFO = 2'b00,
      MODE_SAW  = 2'b01,
      MODE_TRI  = 2'b10,
      MODE_HOLD = 2'b11
   } mode_e;

   typedef enum logic {
      DIR_UP   = 1'b0,
      DIR_DOWN = 1'b1
   } dir_e;

   mode_e               mode_s;
   dir_e                dir;
   logic [DIV_W-1:0]    cnt;
   logic                tick;
   logic                fifo_empty;
   logic                push;
   logic                pop;
   logic                starve;
   logic [CODE_W-1:0]   mem [DEPTH];
   logic [AW-1:0]       wr_ptr;
   logic [AW-1:0]       rd_ptr;

   assign mode_s     = mode_e'(mode);
   // >= rather than == so lowering rate_div below cnt ticks at once instead of wrapping
   assign tick       = run && (cnt >= rate_div);
   assign fifo_empty = (fifo_level == '0);
   assign wr_ready   = (fifo_level != LW'(DEPTH));
   assign push       = wr_valid && wr_ready;
   // No bypass: a sample pushed in the same cycle as a tick on an empty FIFO
   // is not visible to that tick; it is played on the following one.
   assign pop        = tick && (mode_s == MODE_FIFO) && !fifo_empty;
   assign starve     = tick && (mode_s == MODE_FIFO) && fifo_empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (!run || tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + DIV_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= wr_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_level <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)      fifo_level <= fifo_level + LW'(1);
         else if (pop && !push) fifo_level <= fifo_level - LW'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dac_code   <= '0;
         sample_stb <= 1'b0;
         dir        <= DIR_UP;
         underrun   <= 1'b0;
      end else begin
         sample_stb <= tick;
         if (mode_s != MODE_TRI) dir <= DIR_UP;

         if (tick) begin
            case (mode_s)
               MODE_FIFO: if (!fifo_empty) dac_code <= mem[rd_ptr];
               MODE_SAW:  dac_code <= dac_code + CODE_W'(1);
               MODE_TRI: begin
                  // Turn around without repeating the endpoint code.
                  if (dir == DIR_UP) begin
                     if (dac_code == CODE_MAX) begin
                        dac_code <= CODE_MAX - CODE_W'(1);
                        dir      <= DIR_DOWN;
                     end else begin
                        dac_code <= dac_code + CODE_W'(1);
                     end
                  end else begin
                     if (dac_code == '0) begin
                        dac_code <= CODE_W'(1);
                        dir      <= DIR_UP;
                     end else begin
                        dac_code <= dac_code - CODE_W'(1);
                     end
                  end
               end
               default: ;  // hold: code unchanged, strobe still pulses
            endcase
         end

         if (starve)            underrun <= 1'b1;
         else if (clr_underrun) underrun <= 1'b0;
      end
   end

`ifdef DAC_SEQ_UNDERRUN_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         underrun_cnt <= '0;
      end else if (starve) begin
         if (clr_underrun)              underrun_cnt <= 8'd1;
         else if (underrun_cnt != 8'hFF) underrun_cnt <= underrun_cnt + 8'd1;
      end else if (clr_underrun) begin
         underrun_cnt <= '0;
      end
   end
`endif

endmodule

// File: tb/tb_dac_code_sequencer.sv
// Directed bench for dac_code_sequencer: reset, sawtooth, triangle, FIFO play,
// push/pop concurrency, underrun, divider retiming and async reset mid-playback.

module tb_dac_code_sequencer;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       run = 1'b0;
   logic [1:0] mode = 2'b00;
   logic [7:0] rate_div = 8'd0;
   logic       wr_valid = 1'b0;
   logic [3:0] wr_data = 4'd0;
   logic       wr_ready;
   logic       clr_underrun = 1'b0;
   logic [3:0] dac_code;
   logic       sample_stb;
   logic [3:0] fifo_level;
   logic       underrun;
`ifdef DAC_SEQ_UNDERRUN_CNT_EN
   logic [7:0] underrun_cnt;
`endif

   int errors = 0;
   int checks = 0;

   dac_code_sequencer #(.CODE_W(4), .DEPTH(8), .DIV_W(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .run          (run),
      .mode         (mode),
      .rate_div     (rate_div),
      .wr_valid     (wr_valid),
      .wr_data      (wr_data),
      .wr_ready     (wr_ready),
      .clr_underrun (clr_underrun),
      .dac_code     (dac_code),
      .sample_stb   (sample_stb),
      .fifo_level   (fifo_level),
      .underrun     (underrun)
`ifdef DAC_SEQ_UNDERRUN_CNT_EN
      ,
      .underrun_cnt (underrun_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      run          = 1'b0;
      wr_valid     = 1'b0;
      clr_underrun = 1'b0;
      rst          = 1'b1;
      step(1);
      rst = 1'b0;
   endtask

   task automatic push(input logic [3:0] d);
      wr_valid = 1'b1;
      wr_data  = d;
      step(1);
      wr_valid = 1'b0;
   endtask

   initial begin
      logic [3:0] smp [8];
      int exp_code;
      int last;
      int stb_cnt;
      int peaks;
      int zeros;

      smp[0] = 4'd3;  smp[1] = 4'd9;  smp[2] = 4'd5;  smp[3] = 4'd12;
      smp[4] = 4'd1;  smp[5] = 4'd14; smp[6] = 4'd7;  smp[7] = 4'd10;

      // reset state
      step(2);
      chk("rst_code", dac_code, 0);
      chk("rst_stb", sample_stb, 0);
      chk("rst_level", fifo_level, 0);
      chk("rst_ready", wr_ready, 1);
      chk("rst_underrun", underrun, 0);
`ifdef DAC_SEQ_UNDERRUN_CNT_EN
      chk("rst_ucnt", underrun_cnt, 0);
`endif
      rst = 1'b0;
      step(1);

      // sawtooth, tick every 4 clocks
      mode = 2'b01; rate_div = 8'd3; run = 1'b1;
      exp_code = 1; last = 0; stb_cnt = 0;
      for (int i = 1; i <= 68; i++) begin
         step(1);
         if (sample_stb) begin
            chk("saw_code", dac_code, exp_code);
            chk("saw_gap", i - last, 4);
            last = i;
            exp_code = (exp_code + 1) % 16;
            stb_cnt++;
         end
      end
      chk("saw_stb_cnt", stb_cnt, 17);
      chk("saw_final", dac_code, 1);
      run = 1'b0;
      step(3);
      chk("frozen_stb", sample_stb, 0);
      chk("frozen_code", dac_code, 1);

      // triangle from 0, tick every clock
      do_reset();
      mode = 2'b10; rate_div = 8'd0; run = 1'b1;
      peaks = 0; zeros = 0;
      for (int i = 1; i <= 31; i++) begin
         step(1);
         exp_code = (i <= 15) ? i : ((i <= 30) ? 30 - i : i - 30);
         chk("tri_code", dac_code, exp_code);
         chk("tri_stb", sample_stb, 1);
         if (i <= 30) begin
            if (dac_code == 4'd15) peaks++;
            if (dac_code == 4'd0)  zeros++;
         end
      end
      chk("tri_peaks", peaks, 1);
      chk("tri_zeros", zeros, 1);
      run = 1'b0;

      // FIFO fill while frozen, overflow dropped, then play out
      do_reset();
      mode = 2'b00; rate_div = 8'd0;
      for (int i = 0; i < 8; i++) push(smp[i]);
      chk("fill_level", fifo_level, 8);
      chk("fill_ready", wr_ready, 0);
      push(4'd2);
      chk("ovf_level", fifo_level, 8);
      run = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step(1);
         chk("play_code", dac_code, smp[i]);
         chk("play_stb", sample_stb, 1);
      end
      chk("play_level", fifo_level, 0);
      chk("play_no_underrun", underrun, 0);
      step(1);
      chk("starve_hold", dac_code, 10);
      chk("starve_underrun", underrun, 1);
      clr_underrun = 1'b1;
      step(1);
      chk("set_wins_clr", underrun, 1);
      run = 1'b0;
      step(1);
      chk("clr_underrun", underrun, 0);
      clr_underrun = 1'b0;

      // push and pop in the same cycle at level 3
      do_reset();
      mode = 2'b00; rate_div = 8'd0;
      push(4'd4); push(4'd5); push(4'd6);
      chk("pp_level_pre", fifo_level, 3);
      wr_valid = 1'b1; wr_data = 4'd7; run = 1'b1;
      step(1);
      wr_valid = 1'b0;
      chk("pp_code", dac_code, 4);
      chk("pp_level", fifo_level, 3);
      step(1); chk("pp_code2", dac_code, 5); chk("pp_lvl2", fifo_level, 2);
      step(1); chk("pp_code3", dac_code, 6); chk("pp_lvl3", fifo_level, 1);
      step(1); chk("pp_code4", dac_code, 7); chk("pp_lvl4", fifo_level, 0);

      // push into empty FIFO on a tick: no bypass
      wr_valid = 1'b1; wr_data = 4'd11;
      step(1);
      wr_valid = 1'b0;
      chk("nobyp_underrun", underrun, 1);
      chk("nobyp_level", fifo_level, 1);
      chk("nobyp_code", dac_code, 7);
      step(1);
      chk("nobyp_next_code", dac_code, 11);
      chk("nobyp_next_level", fifo_level, 0);
      run = 1'b0;

      // divider: rate_div lowered below cnt ticks next cycle, then period 6
      do_reset();
      mode = 2'b11; rate_div = 8'd200; run = 1'b1;
      step(100);
      chk("div_no_tick", sample_stb, 0);
      rate_div = 8'd5;
      step(1);
      chk("div_immediate", sample_stb, 1);
      chk("hold_code", dac_code, 0);
      for (int i = 1; i <= 6; i++) begin
         step(1);
         chk("div_period", sample_stb, (i == 6) ? 1 : 0);
      end
      run = 1'b0;

      // async reset mid-playback
      do_reset();
      mode = 2'b00;
      for (int i = 0; i < 5; i++) push(smp[i]);
      chk("mid_level_pre", fifo_level, 5);
      rate_div = 8'd3; run = 1'b1;
      step(4);
      chk("mid_code_pre", dac_code, 3);
      chk("mid_level_play", fifo_level, 4);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_code", dac_code, 0);
      chk("mid_rst_level", fifo_level, 0);
      chk("mid_rst_ready", wr_ready, 1);
      chk("mid_rst_underrun", underrun, 0);
      chk("mid_rst_stb", sample_stb, 0);
      run = 1'b0;
      step(1);
      rst = 1'b0;

`ifdef DAC_SEQ_UNDERRUN_CNT_EN
      do_reset();
      mode = 2'b00; rate_div = 8'd0; run = 1'b1;
      step(300);
      chk("ucnt_sat", underrun_cnt, 255);
      clr_underrun = 1'b1;
      step(1);
      chk("ucnt_clr_event", underrun_cnt, 1);
      run = 1'b0;
      step(1);
      chk("ucnt_clr", underrun_cnt, 0);
      clr_underrun = 1'b0;
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
